// File: rtl/wave_spawn_scheduler_pkg.sv
// Shared types and the per-level wave table for the NPC spawn scheduler.
package wave_spawn_scheduler_pkg;

  localparam int TBL_LEVELS = 5;
  localparam int NPC_ID_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_SPAWN,
    ST_DRAIN,
    ST_CLEAR
  } wave_state_t;

  // Index = level; count is NPCs per wave, interval is frame ticks between spawns.
  localparam int WAVE_COUNT    [TBL_LEVELS] = '{4, 6, 8, 10, 10};
  localparam int WAVE_INTERVAL [TBL_LEVELS] = '{60, 48, 36, 24, 16};

endpackage

// File: rtl/wave_spawn_scheduler_if.sv
// Spawn handshake between the scheduler (master) and the NPC array (slave).
interface wave_spawn_scheduler_if;
  import wave_spawn_scheduler_pkg::*;

  logic                spawn_valid;
  logic                spawn_ready;
  logic [NPC_ID_W-1:0] spawn_id;

  modport master (output spawn_valid, output spawn_id, input  spawn_ready);
  modport slave  (input  spawn_valid, input  spawn_id, output spawn_ready);

endinterface

// File: rtl/wave_spawn_scheduler_free_slot_finder.sv
// Combinational lowest-zero priority encoder: returns the first free NPC slot.
module wave_spawn_scheduler_free_slot_finder #(
  parameter int NUM_NPC = 10,
  parameter int ID_W    = 4
) (
  input  logic [NUM_NPC-1:0] i_mask,
  output logic [ID_W-1:0]    o_id,
  output logic               o_found
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_id    = '0;
    for (int i = NUM_NPC - 1; i >= 0; i--) begin
      if (!i_mask[i]) begin
        o_found = 1'b1;
        o_id    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/wave_spawn_scheduler.sv
// Per-level NPC wave sequencer: loads a wave, paces spawns on frame ticks,
// tracks live slots and pulses level_clear once the wave is spawned and dead.
module wave_spawn_scheduler
  import wave_spawn_scheduler_pkg::*;
#(
  parameter int NUM_NPC    = 10,
  parameter int NUM_LEVELS = 5,
  parameter int LEVEL_W    = 3,
  parameter int TIMER_W    = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_tick,
  input  logic                  level_start,
  input  logic [LEVEL_W-1:0]    curr_level,
  input  logic                  pause,
  input  logic [NUM_NPC-1:0]    npc_kill,
  wave_spawn_scheduler_if.master spawn,
  output logic [NUM_NPC-1:0]    npc_active,
  output logic [NPC_ID_W-1:0]   spawned_cnt,
  output logic                  wave_done,
  output logic                  level_clear
);

  localparam int LAST_LVL  = ((NUM_LEVELS < TBL_LEVELS) ? NUM_LEVELS : TBL_LEVELS) - 1;
  localparam int LVL_IDX_W = $clog2(TBL_LEVELS);

  wave_state_t         r_state;
  logic [NPC_ID_W-1:0] r_count;
  logic [TIMER_W-1:0]  r_interval;
  logic [TIMER_W-1:0]  r_timer;
  logic [NPC_ID_W-1:0] r_spawned_cnt;
  logic [NUM_NPC-1:0]  r_active;
  logic                r_spawn_valid;
  logic [NPC_ID_W-1:0] r_spawn_id;
  logic                r_wave_done;
  logic                r_level_clear;

  logic [LVL_IDX_W-1:0] w_lvl;
  logic [NPC_ID_W-1:0]  w_count;
  logic [TIMER_W-1:0]   w_interval;
  logic                 w_in_play;
  logic                 w_handshake;
  logic [NUM_NPC-1:0]   w_spawn_set;
  logic [NUM_NPC-1:0]   w_active_next;
  logic [NPC_ID_W-1:0]  w_free_id;
  logic                 w_found;
  logic [NPC_ID_W-1:0]  w_cnt_inc;

  always_comb begin
    w_lvl      = (int'(curr_level) > LAST_LVL) ? LVL_IDX_W'(LAST_LVL) : LVL_IDX_W'(curr_level);
    w_count    = (WAVE_COUNT[w_lvl] > NUM_NPC) ? NPC_ID_W'(NUM_NPC)
                                               : NPC_ID_W'(WAVE_COUNT[w_lvl]);
    w_interval = (WAVE_INTERVAL[w_lvl] < 1) ? TIMER_W'(1) : TIMER_W'(WAVE_INTERVAL[w_lvl]);
  end

  assign w_in_play   = (r_state == ST_WAIT) || (r_state == ST_SPAWN) || (r_state == ST_DRAIN);
  assign w_handshake = r_spawn_valid && spawn.spawn_ready;
  assign w_spawn_set = w_handshake ? (NUM_NPC'(1) << r_spawn_id) : '0;
  // A spawn overrides a same-cycle kill of the same slot.
  assign w_active_next = w_in_play ? ((r_active & ~npc_kill) | w_spawn_set) : r_active;
  assign w_cnt_inc     = r_spawned_cnt + 1'b1;

  wave_spawn_scheduler_free_slot_finder #(
    .NUM_NPC (NUM_NPC),
    .ID_W    (NPC_ID_W)
  ) u_finder (
    .i_mask  (w_active_next),
    .o_id    (w_free_id),
    .o_found (w_found)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_interval    <= '0;
      r_timer       <= '0;
      r_spawned_cnt <= '0;
      r_active      <= '0;
      r_spawn_valid <= 1'b0;
      r_spawn_id    <= '0;
      r_wave_done   <= 1'b0;
      r_level_clear <= 1'b0;
    end else begin
      r_active      <= w_active_next;
      r_level_clear <= 1'b0;
      if (level_start) begin
        // Start or abort: the wave restarts from a clean slate.
        r_state       <= ST_LOAD;
        r_spawn_valid <= 1'b0;
        r_spawn_id    <= '0;
        r_wave_done   <= 1'b0;
        r_active      <= '0;
        r_spawned_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_LOAD: begin
            r_count       <= w_count;
            r_interval    <= w_interval;
            r_timer       <= w_interval;
            r_spawned_cnt <= '0;
            r_active      <= '0;
            if (w_count == '0) begin
              r_state     <= ST_DRAIN;
              r_wave_done <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (frame_tick && !pause) begin
              r_timer <= r_timer - 1'b1;
              if (r_timer == TIMER_W'(1)) begin
                r_state       <= ST_SPAWN;
                r_spawn_valid <= w_found;
                r_spawn_id    <= w_free_id;
              end
            end
          end
          ST_SPAWN: begin
            if (r_spawn_valid) begin
              if (spawn.spawn_ready) begin
                r_spawned_cnt <= w_cnt_inc;
                r_spawn_valid <= 1'b0;
                r_spawn_id    <= '0;
                if (w_cnt_inc == r_count) begin
                  r_state     <= ST_DRAIN;
                  r_wave_done <= 1'b1;
                end else begin
                  r_timer <= r_interval;
                  r_state <= ST_WAIT;
                end
              end
            end else if (w_found) begin
              // Array was full; a kill has just freed a slot.
              r_spawn_valid <= 1'b1;
              r_spawn_id    <= w_free_id;
            end
          end
          ST_DRAIN: begin
            if (r_active == '0) begin
              r_state       <= ST_CLEAR;
              r_level_clear <= 1'b1;
            end
          end
          ST_CLEAR: begin
            r_state       <= ST_IDLE;
            r_wave_done   <= 1'b0;
            r_spawned_cnt <= '0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign spawn.spawn_valid = r_spawn_valid;
  assign spawn.spawn_id    = r_spawn_id;
  assign npc_active        = r_active;
  assign spawned_cnt       = r_spawned_cnt;
  assign wave_done         = r_wave_done;
  assign level_clear       = r_level_clear;

endmodule
